audio_sample_fifo: RTL and testbench

//  Stereo sample buffer directly upstream of the audio I2S driver. Sample producers

---
 rtl/audio_sample_fifo.sv | 115 +++++++++++
 tb/tb_audio_sample_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
//   Stereo frame buffer placed directly ahead of the I2S driver. Producers push
//   left/right pairs through a valid/ready handshake. The driver pulls one frame
//   per word-clock period with a single-cycle take strobe. A take on an empty
//   buffer plays silence and sets a sticky underrun flag.
//
// Ports
//   inp_clock        audio clock, rising edge
//   inp_reset        asynchronous reset, active low
//   inp_left/right   offered frame, sampled only when a push happens
//   inp_valid        producer offers a frame
//   out_ready        buffer accepts a frame this cycle (registered)
//   inp_take         driver pulls one frame (1-cycle strobe)
//   out_left/right   frame presented to the driver, held until the next take
//   out_level        frames stored, 0..Depth
//   out_almost_full  out_level >= AlmostFull
//   out_underrun     sticky: a take found the buffer empty
//   inp_clear        clears out_underrun; an underrun in the same cycle wins
//   inp_flush        discards all stored frames synchronously
module audio_sample_fifo #(
   parameter int Width      = 16,
   parameter int Depth      = 16,
   parameter int AlmostFull = 12
) (
   input  logic                     inp_clock,
   input  logic                     inp_reset,
   input  logic [Width-1:0]         inp_left,
   input  logic [Width-1:0]         inp_right,
   input  logic                     inp_valid,
   output logic                     out_ready,
   input  logic                     inp_take,
   output logic [Width-1:0]         out_left,
   output logic [Width-1:0]         out_right,
   output logic [$clog2(Depth):0]   out_level,
   output logic                     out_almost_full,
   output logic                     out_underrun,
   input  logic                     inp_clear,
   input  logic                     inp_flush
);

   localparam int AW = $clog2(Depth);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(Depth);
   localparam logic [LW-1:0] AFULL_L = LW'(AlmostFull);

   logic [2*Width-1:0] mem [Depth];
   logic [2*Width-1:0] rd_frame;

   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic [LW-1:0] wr_ptr_next;
   logic [LW-1:0] rd_ptr_next;
   logic [LW-1:0] level_next;

   logic push;
   logic pop;
   logic empty_take;

   // A flush makes the buffer look empty to a same-cycle take, so that take
   // plays silence rather than popping a frame that is being discarded.
   always_comb begin
      push        = inp_valid && out_ready && !inp_flush;
      pop         = inp_take && (out_level != '0) && !inp_flush;
      empty_take  = inp_take && !pop;
      wr_ptr_next = wr_ptr + {{AW{1'b0}}, push};
      rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};
      if (inp_flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end
      level_next  = wr_ptr_next - rd_ptr_next;
      rd_frame    = mem[rd_ptr[AW-1:0]];
   end

   // Storage carries no reset: contents are meaningless once the pointers clear.
   always_ff @(posedge inp_clock) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {inp_left, inp_right};
      end
   end

   always_ff @(posedge inp_clock or negedge inp_reset) begin
      if (!inp_reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         out_level       <= '0;
         out_ready       <= 1'b0;
         out_almost_full <= 1'b0;
         out_left        <= '0;
         out_right       <= '0;
         out_underrun    <= 1'b0;
      end else begin
         wr_ptr          <= wr_ptr_next;
         rd_ptr          <= rd_ptr_next;
         out_level       <= level_next;
         // Ready drops on the edge that accepts the last free slot, so the
         // producer can never overrun the array.
         out_ready       <= (level_next != DEPTH_L);
         out_almost_full <= (level_next >= AFULL_L);
         if (pop) begin
            out_left  <= rd_frame[2*Width-1:Width];
            out_right <= rd_frame[Width-1:0];
         end else if (empty_take) begin
            out_left  <= '0;
            out_right <= '0;
         end
         if (empty_take) begin
            out_underrun <= 1'b1;
         end else if (inp_clear) begin
            out_underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_l;
   logic [15:0] in_r;
   logic        valid;
   logic        ready;
   logic        take;
   logic [15:0] o_l;
   logic [15:0] o_r;
   logic [4:0]  level;
   logic        afull;
   logic        urun;
   logic        clear;
   logic        flush;

   int total = 0;
   int bad   = 0;

   audio_sample_fifo #(.Width(16), .Depth(16), .AlmostFull(12)) dut (
      .inp_clock       (clk),
      .inp_reset       (rst_n),
      .inp_left        (in_l),
      .inp_right       (in_r),
      .inp_valid       (valid),
      .out_ready       (ready),
      .inp_take        (take),
      .out_left        (o_l),
      .out_right       (o_r),
      .out_level       (level),
      .out_almost_full (afull),
      .out_underrun    (urun),
      .inp_clear       (clear),
      .inp_flush       (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [15:0] l;
      logic [15:0] r;
      logic        t;
      logic        c;
      logic        f;
      logic        e_rdy;
      logic [15:0] e_l;
      logic [15:0] e_r;
      logic [4:0]  e_lvl;
      logic        e_af;
      logic        e_ur;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v, input logic [15:0] l, input logic [15:0] r,
                               input logic t, input logic c, input logic f,
                               input logic e_rdy, input logic [15:0] e_l, input logic [15:0] e_r,
                               input logic [4:0] e_lvl, input logic e_af, input logic e_ur);
      vec_t x;
      x.v = v; x.l = l; x.r = r; x.t = t; x.c = c; x.f = f;
      x.e_rdy = e_rdy; x.e_l = e_l; x.e_r = e_r; x.e_lvl = e_lvl; x.e_af = e_af; x.e_ur = e_ur;
      vecs.push_back(x);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_rdy, input logic [15:0] e_l,
                          input logic [15:0] e_r, input logic [4:0] e_lvl,
                          input logic e_af, input logic e_ur);
      chk({tag, ".ready"}, {31'd0, ready}, {31'd0, e_rdy});
      chk({tag, ".left"},  {16'd0, o_l},   {16'd0, e_l});
      chk({tag, ".right"}, {16'd0, o_r},   {16'd0, e_r});
      chk({tag, ".level"}, {27'd0, level}, {27'd0, e_lvl});
      chk({tag, ".afull"}, {31'd0, afull}, {31'd0, e_af});
      chk({tag, ".urun"},  {31'd0, urun},  {31'd0, e_ur});
   endtask

   task automatic idle_inputs();
      valid = 0; take = 0; clear = 0; flush = 0; in_l = 0; in_r = 0;
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();

      // test 1: ordered push then take
      add(0,16'h0000,16'h0000,0,0,0, 1,16'h0000,16'h0000,0,0,0);
      add(1,16'h0001,16'h8001,0,0,0, 1,16'h0000,16'h0000,1,0,0);
      add(1,16'h0002,16'h8002,0,0,0, 1,16'h0000,16'h0000,2,0,0);
      add(1,16'h0003,16'h8003,0,0,0, 1,16'h0000,16'h0000,3,0,0);
      add(1,16'h0004,16'h8004,0,0,0, 1,16'h0000,16'h0000,4,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h0001,16'h8001,3,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h0002,16'h8002,2,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h0003,16'h8003,1,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h0004,16'h8004,0,0,0);
      // test 3: empty take mutes held frame, clear, clear vs set
      add(1,16'h1234,16'h5678,0,0,0, 1,16'h0004,16'h8004,1,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h1234,16'h5678,0,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h0000,16'h0000,0,0,1);
      add(0,16'h0000,16'h0000,0,0,0, 1,16'h0000,16'h0000,0,0,1);
      add(0,16'h0000,16'h0000,0,1,0, 1,16'h0000,16'h0000,0,0,0);
      add(0,16'h0000,16'h0000,1,1,0, 1,16'h0000,16'h0000,0,0,1);
      add(0,16'h0000,16'h0000,0,1,0, 1,16'h0000,16'h0000,0,0,0);
      // test 4: push+take on empty, no bypass
      add(1,16'h00AA,16'h00BB,1,0,0, 1,16'h0000,16'h0000,1,0,1);
      add(0,16'h0000,16'h0000,0,1,0, 1,16'h0000,16'h0000,1,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h00AA,16'h00BB,0,0,0);
      // test 5: flush at level 5 with push
      for (int i = 0; i < 5; i++)
         add(1,16'h0010 + 16'(i),16'h0020 + 16'(i),0,0,0, 1,16'h00AA,16'h00BB,5'(i+1),0,0);
      add(1,16'h0099,16'h0099,0,0,1, 1,16'h00AA,16'h00BB,0,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h0000,16'h0000,0,0,1);
      add(0,16'h0000,16'h0000,0,1,0, 1,16'h0000,16'h0000,0,0,0);
      add(1,16'h0031,16'h0041,0,0,0, 1,16'h0000,16'h0000,1,0,0);
      add(0,16'h0000,16'h0000,1,0,0, 1,16'h0031,16'h0041,0,0,0);
      // take during flush with data stored behaves as empty
      add(1,16'h0055,16'h0066,0,0,0, 1,16'h0031,16'h0041,1,0,0);
      add(0,16'h0000,16'h0000,1,0,1, 1,16'h0000,16'h0000,0,0,1);
      add(0,16'h0000,16'h0000,0,1,0, 1,16'h0000,16'h0000,0,0,0);

      #2;
      chk_all("reset", 0, 16'h0000, 16'h0000, 0, 0, 0);
      #10 rst_n = 1;

      for (int k = 0; k < vecs.size(); k++) begin
         valid = vecs[k].v; in_l = vecs[k].l; in_r = vecs[k].r;
         take = vecs[k].t; clear = vecs[k].c; flush = vecs[k].f;
         @(posedge clk); #1;
         chk_all($sformatf("vec%0d", k), vecs[k].e_rdy, vecs[k].e_l, vecs[k].e_r,
                 vecs[k].e_lvl, vecs[k].e_af, vecs[k].e_ur);
      end
      idle_inputs();

      // test 2: fill to full with valid held, then backpressure
      for (int i = 0; i < 16; i++) begin
         valid = 1; in_l = 16'h0100 + 16'(i); in_r = 16'h0200 + 16'(i);
         @(posedge clk); #1;
         chk($sformatf("fill%0d.level", i), {27'd0, level}, 32'(i + 1));
         chk($sformatf("fill%0d.afull", i), {31'd0, afull}, {31'd0, (i + 1) >= 12});
         chk($sformatf("fill%0d.ready", i), {31'd0, ready}, {31'd0, (i + 1) != 16});
      end
      in_l = 16'h0110; in_r = 16'h0210;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("hold.ready", {31'd0, ready}, 32'd0);
         chk("hold.level", {27'd0, level}, 32'd16);
      end
      take = 1;
      @(posedge clk); #1;
      take = 0;
      chk_all("full_take", 1, 16'h0100, 16'h0200, 15, 1, 0);
      @(posedge clk); #1;
      valid = 0;
      chk("refill.level", {27'd0, level}, 32'd16);
      chk("refill.ready", {31'd0, ready}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         take = 1;
         @(posedge clk); #1;
         chk_all($sformatf("drain%0d", i), 1, 16'h0101 + 16'(i), 16'h0201 + 16'(i),
                 5'(15 - i), (15 - i) >= 12, 0);
      end
      take = 0;

      // test 6: reset mid-stream at level 7 with takes active
      for (int i = 0; i < 9; i++) begin
         valid = 1; in_l = 16'h0A00 + 16'(i); in_r = 16'h0B00 + 16'(i);
         @(posedge clk); #1;
      end
      valid = 0;
      chk("pre6.level", {27'd0, level}, 32'd9);
      take = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all("pre_rst", 1, 16'h0A01, 16'h0B01, 7, 0, 0);
      #1 rst_n = 0;
      #1;
      chk_all("async_rst", 0, 16'h0000, 16'h0000, 0, 0, 0);
      take = 0;
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      chk_all("post_rst", 1, 16'h0000, 16'h0000, 0, 0, 0);
      take = 1;
      @(posedge clk); #1;
      take = 0;
      chk_all("post_rst_take", 1, 16'h0000, 16'h0000, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
